// File: rtl/graphics_pkg.sv
// graphics_pkg: shared VGA timing defaults, pixel format and colour expansion for the scanout path.
//   VGA_*           default 640x480@60 timing (pixel clocks / lines) and framebuffer geometry
//   COUNT_W         width of the horizontal/vertical position counters
//   pixel_rgb332    framebuffer byte layout RRRGGGBB
//   scan_flags      per-pixel status carried alongside the colour through the read pipeline
//   Rgb332ToRgb888  replicates each field's MSBs to fill 8 bits, so full-scale maps to 8'hFF
package graphics_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BACK = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BACK = 33;
    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END = VGA_V_SYNC_START + VGA_V_SYNC;
    localparam int VGA_SCALE_SHIFT = 1;
    localparam int VGA_FB_WIDTH = VGA_H_VISIBLE >> VGA_SCALE_SHIFT;
    localparam logic [31:0] VGA_FB_BASE = 32'h0;
    localparam int COUNT_W = 12;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } pixel_rgb332;

    typedef struct packed {
        logic visible;
        logic hSync;
        logic vSync;
        logic vBlank;
        logic frameStart;
    } scan_flags;

    localparam scan_flags FLAGS_RESET = '{visible: 1'b0, hSync: 1'b1, vSync: 1'b1, vBlank: 1'b0, frameStart: 1'b0};

    function automatic logic [23:0] Rgb332ToRgb888(input pixel_rgb332 p);
        return {p.r, p.r, p.r[2:1], p.g, p.g, p.g[2:1], {4{p.b}}};
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster position counters and raw (undelayed) timing flags.
//   Clock, Reset         pixel clock, asynchronous active-high reset
//   HCount, VCount       current raster position (stage 0)
//   Visible              position lies inside the active picture
//   HSyncRaw, VSyncRaw   active-low sync for the current position
//   LineEnd, FrameEnd    last pixel of a line / of a frame
module vga_timing
    import graphics_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT = VGA_H_FRONT,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BACK = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT = VGA_V_FRONT,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BACK = VGA_V_BACK
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [COUNT_W-1:0] HCount,
    output logic [COUNT_W-1:0] VCount,
    output logic               Visible,
    output logic               HSyncRaw,
    output logic               VSyncRaw,
    output logic               LineEnd,
    output logic               FrameEnd
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

    assign LineEnd = HCount == COUNT_W'(H_TOTAL - 1);
    assign FrameEnd = LineEnd && VCount == COUNT_W'(V_TOTAL - 1);
    assign Visible = HCount < COUNT_W'(H_VISIBLE) && VCount < COUNT_W'(V_VISIBLE);
    assign HSyncRaw = !(HCount >= COUNT_W'(H_SYNC_START) && HCount < COUNT_W'(H_SYNC_START + H_SYNC));
    assign VSyncRaw = !(VCount >= COUNT_W'(V_SYNC_START) && VCount < COUNT_W'(V_SYNC_START + V_SYNC));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            HCount <= '0;
            VCount <= '0;
        end else begin
            HCount <= LineEnd ? '0 : HCount + 1'b1;
            if (LineEnd)
                VCount <= FrameEnd ? '0 : VCount + 1'b1;
        end
    end
endmodule

// File: rtl/graphics_scanout.sv
// graphics_scanout: framebuffer read side; generates VGA timing, fetches scaled pixels and expands RGB332.
//   Clock, Reset              pixel clock, asynchronous active-high reset
//   GPUAddress                byte address of the pixel at the current raster position
//   GPUData                   byte returned for the previous cycle's GPUAddress
//   Red, Green, Blue          8-bit colour, zero outside the visible area
//   HSync, VSync              active-low sync
//   DisplayEnable             output pixel lies in the visible area
//   FrameStart                one-cycle pulse with output pixel (0,0)
//   VBlank                    output line is below the visible area
// Every output is two clocks behind the address that fetched its pixel.
module graphics_scanout
    import graphics_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT = VGA_H_FRONT,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BACK = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT = VGA_V_FRONT,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BACK = VGA_V_BACK,
    parameter int SCALE_SHIFT = VGA_SCALE_SHIFT,
    parameter int FB_WIDTH = H_VISIBLE >> SCALE_SHIFT,
    parameter logic [31:0] FB_BASE = VGA_FB_BASE
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] GPUAddress,
    input  logic [7:0]  GPUData,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        HSync,
    output logic        VSync,
    output logic        DisplayEnable,
    output logic        FrameStart,
    output logic        VBlank
);
    logic [COUNT_W-1:0] hCount, vCount, nextLine;
    logic               visible, hSyncRaw, vSyncRaw, lineEnd, frameEnd, rowAdvance;
    logic [31:0]        rowBase;
    logic [23:0]        rgb;
    scan_flags          flags0, flags1, flags2;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) timing (
        .Clock(Clock), .Reset(Reset), .HCount(hCount), .VCount(vCount), .Visible(visible),
        .HSyncRaw(hSyncRaw), .VSyncRaw(vSyncRaw), .LineEnd(lineEnd), .FrameEnd(frameEnd)
    );

    // A framebuffer row is reused for 2^SCALE_SHIFT screen lines, so the row base only
    // steps by the stride when the next line begins a new framebuffer row.
    assign nextLine = vCount + 1'b1;
    assign rowAdvance = (nextLine & COUNT_W'((1 << SCALE_SHIFT) - 1)) == '0 && nextLine < COUNT_W'(V_VISIBLE);
    assign GPUAddress = visible ? rowBase + 32'(hCount >> SCALE_SHIFT) : rowBase;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            rowBase <= FB_BASE;
        else if (frameEnd)
            rowBase <= FB_BASE;
        else if (lineEnd && rowAdvance)
            rowBase <= rowBase + 32'(FB_WIDTH);
    end

    assign flags0 = '{
        visible: visible,
        hSync: hSyncRaw,
        vSync: vSyncRaw,
        vBlank: vCount >= COUNT_W'(V_VISIBLE),
        frameStart: hCount == '0 && vCount == '0
    };

    // flags1 lines up with GPUData; flags2 lines up with the registered colour.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flags1 <= FLAGS_RESET;
            flags2 <= FLAGS_RESET;
            rgb <= '0;
        end else begin
            flags1 <= flags0;
            flags2 <= flags1;
            rgb <= flags1.visible ? Rgb332ToRgb888(pixel_rgb332'(GPUData)) : '0;
        end
    end

    assign {Red, Green, Blue} = rgb;
    assign DisplayEnable = flags2.visible;
    assign HSync = flags2.hSync;
    assign VSync = flags2.vSync;
    assign VBlank = flags2.vBlank;
    assign FrameStart = flags2.frameStart;
endmodule
